// File: rtl/caesar_pkg.sv
// rtl/caesar_pkg.sv - shared constants and key helper for the Caesar decrypt path
// Contents:
//   ALPHABET     letters per case
//   ASC_*        ASCII bounds of the two letter ranges
//   KEY_W        key register width
//   key_reduce   folds raw 5-bit keys 26-31 back into 0-5
package caesar_pkg;

    localparam int          ALPHABET    = 26;
    localparam int          KEY_W       = 5;
    localparam logic [7:0]  ASC_UPPER_A = 8'h41;
    localparam logic [7:0]  ASC_UPPER_Z = 8'h5A;
    localparam logic [7:0]  ASC_LOWER_A = 8'h61;
    localparam logic [7:0]  ASC_LOWER_Z = 8'h7A;

    // A single subtraction is enough: the 5-bit input never exceeds 31 < 2*26.
    function automatic logic [KEY_W-1:0] key_reduce(input logic [KEY_W-1:0] k);
        return (k >= KEY_W'(ALPHABET)) ? k - KEY_W'(ALPHABET) : k;
    endfunction

endpackage

// File: rtl/caesar_unshift.sv
// rtl/caesar_unshift.sv - combinational Caesar shift-back of one ASCII character
// Ports:
//   in_char   in   CHAR_W  ciphertext character
//   key       in   KEY_W   shift amount, expected 0-25
//   out_char  out  CHAR_W  letters rotated back by key, other codes unchanged
module caesar_unshift
    import caesar_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] in_char,
    input  logic [KEY_W-1:0]  key,
    output logic [CHAR_W-1:0] out_char
);

    logic              w_upper;
    logic              w_lower;
    logic [CHAR_W-1:0] w_base;
    logic [5:0]        w_off;
    logic [5:0]        w_sum;
    logic [5:0]        w_mod;

    assign w_upper = (in_char >= CHAR_W'(ASC_UPPER_A)) && (in_char <= CHAR_W'(ASC_UPPER_Z));
    assign w_lower = (in_char >= CHAR_W'(ASC_LOWER_A)) && (in_char <= CHAR_W'(ASC_LOWER_Z));
    assign w_base  = w_upper ? CHAR_W'(ASC_UPPER_A) : CHAR_W'(ASC_LOWER_A);

    // Both bases have distinct low 6 bits and the letter offset fits in 0-25,
    // so the offset can be taken from the low 6 bits alone.
    assign w_off   = in_char[5:0] - w_base[5:0];
    // Adding 26 first keeps the 6-bit result non-negative (max 25+26 = 51).
    assign w_sum   = w_off + 6'(ALPHABET) - {1'b0, key};
    assign w_mod   = (w_sum >= 6'(ALPHABET)) ? w_sum - 6'(ALPHABET) : w_sum;

    assign out_char = (w_upper || w_lower) ? (w_base + CHAR_W'(w_mod)) : in_char;

endmodule

// File: rtl/caesar_decoder.sv
// rtl/caesar_decoder.sv - streaming Caesar decryptor with loadable key and optional key sweep
// Optional feature macro: CAESAR_SWEEP_EN (auto key stepping on slow tick)
// Ports:
//   CLOCK_50   in   1       system clock
//   RESET      in   1       asynchronous active-high reset
//   key_load   in   1       load key_in into key register
//   key_in     in   5       new key, 26-31 reduced by 26
//   sweep_en   in   1       enable automatic key stepping (sweep build only)
//   in_valid   in   1       ciphertext present
//   in_ready   out  1       character accepted this cycle when in_valid
//   in_char    in   CHAR_W  ciphertext
//   out_valid  out  1       plaintext present
//   out_ready  in   1       downstream takes out_char
//   out_char   out  CHAR_W  plaintext
//   key_cur    out  5       active key 0-25
module caesar_decoder
    import caesar_pkg::*;
#(
    parameter int TICK_W = 25,
    parameter int CHAR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              sweep_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic [KEY_W-1:0]  key_cur
);

    logic [KEY_W-1:0]  r_key;
    logic              r_out_valid;
    logic [CHAR_W-1:0] r_out_char;
    logic [CHAR_W-1:0] w_dec;
    logic              w_accept;

    // The buffer can take a new character when empty or when its current one
    // leaves in the same cycle; in_valid never feeds back into in_ready.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign key_cur   = r_key;

    // Decoding uses r_key before any same-cycle key_load takes effect.
    caesar_unshift #(
        .CHAR_W   (CHAR_W)
    ) u_unshift (
        .in_char  (in_char),
        .key      (r_key),
        .out_char (w_dec)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_char  <= w_dec;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef CAESAR_SWEEP_EN
    logic [TICK_W-1:0] r_tick;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    // An explicit load wins over the sweep step on a wrap cycle.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_key <= '0;
        end else if (key_load) begin
            r_key <= key_reduce(key_in);
        end else if (sweep_en && (r_tick == '0)) begin
            r_key <= (r_key == KEY_W'(ALPHABET - 1)) ? '0 : r_key + KEY_W'(1);
        end
    end
`else
    // Sweep hardware is absent; sweep_en and TICK_W are intentionally unused.
    logic [TICK_W-1:0] w_unused_sweep;
    assign w_unused_sweep = {TICK_W{sweep_en}};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_key <= '0;
        end else if (key_load) begin
            r_key <= key_reduce(key_in);
        end
    end
`endif

endmodule
